// File: rtl/ex_stage_mc.sv
// rtl/ex_stage_mc.sv - registered execute stage with iterative multiply/divide
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid, flush         instruction present / kill in-flight work and this cycle's input
//   operand_1/2, imm        register operands and sign-extended immediate
//   mem_fwd, wb_fwd         forwarding data; sel_val1/2 pick reg(0,3)/MEM(1)/WB(2)
//   pc_plus4, jidx          branch/jump target sources
//   shamt, aluctrl          shift amount and operation code
//   alusrc, shift, branch, branch_ne, jump   datapath controls
//   destReg, MemWrite, memtoreg, regWrite, is_byte   carried to EX/MEM
//   stall                   upstream must hold its inputs
//   out_valid and *_out     EX/MEM register contents; controls and b_or_j gated by out_valid
module ex_stage_mc #(
    parameter int XLEN   = 32,
    parameter int JIDX_W = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [XLEN-1:0]   operand_1,
    input  logic [XLEN-1:0]   operand_2,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   mem_fwd,
    input  logic [XLEN-1:0]   wb_fwd,
    input  logic [1:0]        sel_val1,
    input  logic [1:0]        sel_val2,
    input  logic [XLEN-1:0]   pc_plus4,
    input  logic [JIDX_W-1:0] jidx,
    input  logic [4:0]        shamt,
    input  logic [4:0]        aluctrl,
    input  logic              alusrc,
    input  logic              shift,
    input  logic              branch,
    input  logic              branch_ne,
    input  logic              jump,
    input  logic [4:0]        destReg,
    input  logic              MemWrite,
    input  logic              memtoreg,
    input  logic              regWrite,
    input  logic              is_byte,
    output logic              stall,
    output logic              out_valid,
    output logic [XLEN-1:0]   alu_out,
    output logic [XLEN-1:0]   operand_2_out,
    output logic [XLEN-1:0]   next_pc,
    output logic [4:0]        destReg_out,
    output logic              MemWrite_out,
    output logic              memtoreg_out,
    output logic              regWrite_out,
    output logic              is_byte_out,
    output logic              b_or_j
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN + 1);
    // Bits of pc_plus4 replaced by {jidx, 2'b00} on a jump.
    localparam logic [XLEN-1:0] JMASK = {XLEN{1'b1}} >> (XLEN - JIDX_W - 2);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] src1, src2, a_val, b_val, alu_res, pc_nxt;
    logic            zero, bj, is_md;

    // Multi-cycle operation state
    logic [4:0]      op_q;
    logic [XLEN-1:0] mcand_q;    // multiplicand or divisor
    logic [XLEN-1:0] acc_q;      // product high half or partial remainder
    logic [XLEN-1:0] mq_q;       // multiplier/product low half or dividend/quotient
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] src2_q, npc_q;
    logic [4:0]      dest_q;
    logic            bj_q, mw_q, mtr_q, rw_q, isb_q;

    logic [XLEN:0]   mul_sum, div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_diff, acc_nxt, mq_nxt, md_res;

    // Registered controls, exposed only while the entry is valid
    logic            mw_r, mtr_r, rw_r, isb_r, bj_r;

    always_comb begin
        case (sel_val1)
            2'd1:    src1 = mem_fwd;
            2'd2:    src1 = wb_fwd;
            default: src1 = operand_1;
        endcase
        case (sel_val2)
            2'd1:    src2 = mem_fwd;
            2'd2:    src2 = wb_fwd;
            default: src2 = operand_2;
        endcase
        a_val = shift ? XLEN'(shamt) : src1;
        b_val = alusrc ? imm : src2;
    end

    always_comb begin
        alu_res = '0;
        case (aluctrl)
            5'd0:    alu_res = a_val + b_val;
            5'd1:    alu_res = a_val - b_val;
            5'd2:    alu_res = a_val & b_val;
            5'd3:    alu_res = a_val | b_val;
            5'd4:    alu_res = a_val ^ b_val;
            5'd5:    alu_res = ~(a_val | b_val);
            5'd6:    alu_res = XLEN'($signed(a_val) < $signed(b_val));
            5'd7:    alu_res = XLEN'(a_val < b_val);
            5'd8:    alu_res = b_val << a_val[SHW-1:0];
            5'd9:    alu_res = b_val >> a_val[SHW-1:0];
            5'd10:   alu_res = $signed(b_val) >>> a_val[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    assign zero   = (src1 == src2);
    assign bj     = (branch & (branch_ne ? ~zero : zero)) | jump;
    assign pc_nxt = jump ? ((pc_plus4 & ~JMASK) | (XLEN'(jidx) << 2))
                         : pc_plus4 + (imm << 2);
    assign is_md  = (aluctrl[4:2] == 3'b100);

    // One iteration of shift-add multiply or restoring divide.
    // A zero divisor always "fits", giving an all-ones quotient and
    // leaving the dividend bits shifted into the remainder.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {acc_q, mq_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, mcand_q};
        div_diff  = div_shift[XLEN-1:0] - mcand_q;
        if (state == MUL) begin
            acc_nxt = mul_sum[XLEN:1];
            mq_nxt  = {mul_sum[0], mq_q[XLEN-1:1]};
        end else if (div_ge) begin
            acc_nxt = div_diff;
            mq_nxt  = {mq_q[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt = div_shift[XLEN-1:0];
            mq_nxt  = {mq_q[XLEN-2:0], 1'b0};
        end
        // 16 MUL / 18 DIVU take the low/quotient half, 17 MULHU / 19 REMU the other
        md_res = op_q[0] ? acc_nxt : mq_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && is_md && !flush) begin
                    stall     = 1'b1;
                    state_nxt = aluctrl[1] ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                stall = 1'b1;
                if (cnt_q == CW'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            alu_out       <= '0;
            operand_2_out <= '0;
            next_pc       <= '0;
            destReg_out   <= '0;
            {mw_r, mtr_r, rw_r, isb_r, bj_r} <= '0;
            op_q <= '0; mcand_q <= '0; acc_q <= '0; mq_q <= '0; cnt_q <= '0;
            src2_q <= '0; npc_q <= '0; dest_q <= '0;
            {bj_q, mw_q, mtr_q, rw_q, isb_q} <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (state == IDLE) begin
            out_valid <= in_valid && !is_md;
            if (in_valid && is_md) begin
                op_q    <= aluctrl;
                mcand_q <= b_val;
                mq_q    <= a_val;
                acc_q   <= '0;
                cnt_q   <= CW'(XLEN);
                src2_q  <= src2;
                npc_q   <= pc_nxt;
                dest_q  <= destReg;
                {bj_q, mw_q, mtr_q, rw_q, isb_q} <= {bj, MemWrite, memtoreg, regWrite, is_byte};
            end else if (in_valid) begin
                alu_out       <= alu_res;
                operand_2_out <= src2;
                next_pc       <= pc_nxt;
                destReg_out   <= destReg;
                {bj_r, mw_r, mtr_r, rw_r, isb_r} <= {bj, MemWrite, memtoreg, regWrite, is_byte};
            end
        end else begin
            acc_q <= acc_nxt;
            mq_q  <= mq_nxt;
            cnt_q <= cnt_q - CW'(1);
            out_valid <= (cnt_q == CW'(1));
            if (cnt_q == CW'(1)) begin
                alu_out       <= md_res;
                operand_2_out <= src2_q;
                next_pc       <= npc_q;
                destReg_out   <= dest_q;
                {bj_r, mw_r, mtr_r, rw_r, isb_r} <= {bj_q, mw_q, mtr_q, rw_q, isb_q};
            end
        end
    end

    assign MemWrite_out = mw_r  & out_valid;
    assign memtoreg_out = mtr_r & out_valid;
    assign regWrite_out = rw_r  & out_valid;
    assign is_byte_out  = isb_r & out_valid;
    assign b_or_j       = bj_r  & out_valid;

endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
Parametrised, registered execute stage for the pipelined core. It keeps the single-cycle ALU, forwarding, branch and jump resolution of the current execute stage. It adds an iterative multiply/divide unit that stalls the front of the pipe. All results are captured into an internal EX/MEM register, so downstream sees one registered output set per instruction.

Parameters:
XLEN, 32, datapath width; must be at least 8.
JIDX_W, 26, jump-index field width; must be at most XLEN-2.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  decoded instruction present
flush  in  1  kill the in-flight instruction and the input of this cycle
operand_1, operand_2, imm  in  XLEN  register operands and sign-extended immediate
mem_fwd, wb_fwd  in  XLEN  forwarding data from MEM and WB
sel_val1, sel_val2  in  2  operand select: 0 reg, 1 MEM, 2 WB, 3 reg
pc_plus4  in  XLEN  pc+4 of the instruction
jidx  in  JIDX_W  jump index
shamt  in  5  shift amount field
aluctrl  in  5  operation code
alusrc, shift, branch, branch_ne, jump  in  1  datapath controls
destReg  in  5  destination register
MemWrite, memtoreg, regWrite, is_byte  in  1  pass-through controls
stall  out  1  upstream must hold its inputs
out_valid  out  1  EX/MEM entry valid
alu_out, operand_2_out, next_pc  out  XLEN  registered results
destReg_out  out  5  registered destination
MemWrite_out, memtoreg_out, regWrite_out, is_byte_out  out  1  registered controls, gated by out_valid
b_or_j  out  1  redirect pulse, valid with out_valid

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; every output 0; stall 0.
- Operand selection:
  - src1 comes from operand_1, mem_fwd or wb_fwd according to sel_val1; src2 likewise according to sel_val2.
  - The B input is imm when alusrc=1, otherwise src2.
  - The A input is zero-extended shamt when shift=1, otherwise src1.
- aluctrl codes (XLEN-wide results, wrap-around arithmetic):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA; shift B by A[log2 XLEN-1:0].
  - 16 MUL (low XLEN bits), 17 MULHU (high XLEN bits), 18 DIVU, 19 REMU.
  - Any other code produces 0.
- Branch and jump:
  - zero = (src1 == src2).
  - taken = branch & (branch_ne ? ~zero : zero).
  - b_or_j = taken | jump.
  - next_pc = jump ? {pc_plus4[XLEN-1:JIDX_W+2], jidx, 2'b00} : pc_plus4 + (imm << 2).
  - Branch and jump instructions never use codes 16-19.
- State machine: IDLE, MUL, DIV.
  - IDLE, in_valid=1, single-cycle code, no flush: the EX/MEM register loads next edge with out_valid=1 (latency 1).
  - IDLE, in_valid=0: out_valid=0 next edge.
  - IDLE, in_valid=1, codes 16-19: capture A, B and the controls; clear the accumulator; count=XLEN; go to MUL (16/17) or DIV (18/19); out_valid=0; stall=1 combinationally from this cycle.
  - MUL: radix-2 shift-add with a 2*XLEN-bit product.
  - DIV: restoring divide, one quotient bit per cycle.
  - Each busy cycle decrements count. When count reaches 1, the result is written into EX/MEM with out_valid=1 and the state returns to IDLE.
  - Total latency is XLEN+1 edges from accept to out_valid, with stall=1 for XLEN+1 cycles including the accept cycle. stall drops in the cycle the result is written.
  - out_valid=0 on every busy cycle except the last.
- Divide by zero: quotient all ones, remainder equals the dividend. No exception is raised.
- Inputs presented while stall=1 are not sampled. Upstream holds them, and they are accepted in the first cycle after stall falls.
- flush=1, highest priority after reset:
  - Next edge: state IDLE, out_valid=0, control outputs 0, b_or_j 0.
  - Any multi-cycle operation in progress is discarded.
  - The input of the same cycle is not accepted.
  - stall=0 in the cycle after the flush.
- Pass-through controls are registered with the instruction and forced to 0 whenever out_valid=0. operand_2_out carries src2.

Test Plan:
- ADD: sel=0, operand_1=5, operand_2=7, alusrc=0 -> next cycle out_valid=1, alu_out=12; SUB 3-5 -> 0xFFFFFFFE.
- Forwarding and shift: sel_val1=1, mem_fwd=0x10, SLL with shift=1, shamt=4, src2=1 -> alu_out=0x10; SRA of 0x80000000 by 31 -> 0xFFFFFFFF.
- Branch: BNE with src1=3, src2=4, pc_plus4=0x100, imm=2 -> b_or_j=1, next_pc=0x108; BEQ same operands -> b_or_j=0.
- Jump: jidx=0x40, pc_plus4=0x10000004 -> next_pc=0x10000100, b_or_j=1.
- MUL 0xFFFFFFFF*2 -> stall held for 33 cycles, then out_valid=1, alu_out=0xFFFFFFFE; MULHU same operands -> 1.
- DIVU 100/7 -> 14, REMU -> 2; divide by zero -> 0xFFFFFFFF; flush in busy cycle 10 -> out_valid stays 0, stall=0 next cycle, a following ADD completes normally.
